// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine shared types and constants.
// State encoding, mode values and default bus widths.
package mem_copy_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 9;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    FILL,
    DONE
  } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Command and memory-port bundle of the copy engine.
// master = engine side, slave = control path / memory side.
interface mem_copy_engine_if #(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_copy_pkg::DATA_W_DEF,
  parameter int LEN_W  = mem_copy_pkg::LEN_W_DEF
);

  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (
    input  start, mode, src_addr, dst_addr,
    input  length, fill_value, read_data,
    output busy, done, MemRead, MemWrite,
    output address, write_data
  );

  modport slave (
    output start, mode, src_addr, dst_addr,
    output length, fill_value, read_data,
    input  busy, done, MemRead, MemWrite,
    input  address, write_data
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / block fill bus initiator for the data memory.
// Moore outputs; write data in WR passes the memory read port.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_copy_engine_if.master  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  // State, pointers and latched command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
    end
  end

  // Next state, command latch and pointer/count stepping.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          rem_d  = bus.length;
          fill_d = bus.fill_value;
          if (bus.length == '0)
            state_d = DONE;
          else if (bus.mode == MODE_FILL)
            state_d = FILL;
          else
            state_d = RD;
        end
      end
      RD: state_d = WR;
      WR: begin
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        rem_d   = rem_q - LEN_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? DONE : RD;
      end
      FILL: begin
        dst_d   = dst_q + ADDR_W'(1);
        rem_d   = rem_q - LEN_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? DONE : FILL;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port and status decode from registered state.
  always_comb begin
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    unique case (state_q)
      RD: begin
        bus.busy    = 1'b1;
        bus.MemRead = 1'b1;
        bus.address = src_q;
      end
      WR: begin
        bus.busy       = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.address    = dst_q;
        bus.write_data = bus.read_data;
      end
      FILL: begin
        bus.busy       = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.address    = dst_q;
        bus.write_data = fill_q;
      end
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine.
// Behavioural 256-word memory plus array reference model.
module tb_mem_copy_engine;
  import mem_copy_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_copy_engine_if bus();

  mem_copy_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem  [256];
  logic [15:0] refm [256];
  logic        pl_we;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;
  logic [15:0] rd_q;

  // Data memory: registered read, zero when not reading.
  always_ff @(posedge clk) begin
    if (pl_we)
      mem[pl_a] <= pl_d;
    else if (bus.MemWrite)
      mem[bus.address[7:0]] <= bus.write_data;
    rd_q <= bus.MemRead ? mem[bus.address[7:0]] : 16'h0;
  end

  assign bus.read_data = rd_q;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_a  = a[7:0];
    pl_d  = d;
    refm[a & 255] = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic mem_cmp(input string tag);
    for (int i = 0; i < 256; i++)
      check(tag, {16'h0, mem[i]}, {16'h0, refm[i]});
  endtask

  // Ascending word-by-word transfer on the reference array.
  task automatic model(input logic m, input int s, input int d,
                       input int n, input logic [15:0] f);
    for (int k = 0; k < n; k++)
      refm[(d + k) & 255] = m ? f : refm[(s + k) & 255];
  endtask

  task automatic scramble();
    bus.start      = 1'($urandom_range(0, 1));
    bus.mode       = 1'($urandom_range(0, 1));
    bus.src_addr   = 16'($urandom);
    bus.dst_addr   = 16'($urandom);
    bus.length     = 9'($urandom_range(0, 256));
    bus.fill_value = 16'($urandom);
  endtask

  task automatic run_cmd(input string tag, input logic m,
                         input int s, input int d,
                         input int len, input logic [15:0] f);
    int lat, cyc, busy_n, rd_n, wr_n, both_n, rdk;
    bit seen;
    lat = (len == 0) ? 1 : (m ? len + 1 : 2 * len + 1);
    cyc = 0; busy_n = 0; rd_n = 0; wr_n = 0;
    both_n = 0; rdk = 0; seen = 0;
    @(negedge clk);
    bus.mode       = m;
    bus.src_addr   = 16'(s);
    bus.dst_addr   = 16'(d);
    bus.length     = 9'(len);
    bus.fill_value = f;
    bus.start      = 1'b1;
    for (int i = 0; i < 700 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_n++;
      if (bus.MemRead) begin
        rd_n++;
        check({tag, "_rd_addr"}, {24'h0, bus.address[7:0]},
              32'((s + rdk) & 255));
        rdk++;
      end
      if (bus.MemWrite) wr_n++;
      if (bus.MemRead && bus.MemWrite) both_n++;
      if (bus.done) begin
        seen = 1;
        check({tag, "_done_lat"}, cyc, lat);
        check({tag, "_done_busy"}, {31'h0, bus.busy}, 0);
        bus.start = 1'b0;
      end else begin
        scramble();
      end
    end
    bus.start = 1'b0;
    if (!seen) check({tag, "_done_timeout"}, 0, 1);
    check({tag, "_busy_cycles"}, busy_n, lat - 1);
    check({tag, "_reads"}, rd_n, m ? 0 : len);
    check({tag, "_writes"}, wr_n, len);
    check({tag, "_rd_wr_both"}, both_n, 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, {31'h0, bus.done}, 0);
    model(m, s, d, len, f);
    mem_cmp({tag, "_mem"});
  endtask

  initial begin
    int dn, cyc;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    bus.start = 1'b0; bus.mode = 1'b0;
    bus.src_addr = '0; bus.dst_addr = '0;
    bus.length = '0; bus.fill_value = '0;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'h0, bus.busy}, 0);
    check("rst_done", {31'h0, bus.done}, 0);
    check("rst_memread", {31'h0, bus.MemRead}, 0);
    check("rst_memwrite", {31'h0, bus.MemWrite}, 0);
    check("rst_address", {16'h0, bus.address}, 0);
    check("rst_wdata", {16'h0, bus.write_data}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 256; i++) poke(i, 16'($urandom));

    poke(0, 16'hAAAA); poke(1, 16'hBBBB);
    poke(2, 16'hCCCC); poke(3, 16'hDDDD);
    run_cmd("copy4", MODE_COPY, 0, 'h10, 4, 16'h0);
    run_cmd("fill3", MODE_FILL, 0, 'h20, 3, 16'h5A5A);
    run_cmd("zero", MODE_COPY, 'h30, 'h31, 0, 16'h0);
    run_cmd("zerof", MODE_FILL, 'h30, 'h31, 0, 16'h1234);
    run_cmd("wrap", MODE_COPY, 'hFE, 'h40, 4, 16'h0);
    poke('h50, 16'h1111);
    run_cmd("overlap", MODE_COPY, 'h50, 'h51, 3, 16'h0);
    run_cmd("fillwrap", MODE_FILL, 0, 'hFFFD, 6, 16'hC0DE);

    // Reset during the second WR of an 8-word copy.
    @(negedge clk);
    bus.mode = MODE_COPY; bus.src_addr = 16'h80;
    bus.dst_addr = 16'hA0; bus.length = 9'd8;
    bus.start = 1'b1;
    cyc = 0;
    while (cyc < 4) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
    end
    check("rstmid_in_wr", {31'h0, bus.MemWrite}, 1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_memwrite", {31'h0, bus.MemWrite}, 0);
    check("rstmid_busy", {31'h0, bus.busy}, 0);
    check("rstmid_address", {16'h0, bus.address}, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) dn++;
    end
    check("rstmid_quiet", dn, 0);
    model(MODE_COPY, 'h80, 'hA0, 1, 16'h0);
    mem_cmp("rstmid_mem");
    run_cmd("after_rst", MODE_COPY, 'h80, 'hA0, 8, 16'h0);

    for (int t = 0; t < 16; t++) begin
      logic m;
      int s, d, n;
      m = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, 65535));
      d = int'($urandom_range(0, 65535));
      n = int'($urandom_range(0, 48));
      if (t == 15) n = 256;
      run_cmd("rand", m, s, d, n, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
